// File: rtl/rot_pkg.sv
// -----------------------------------------------------------------------------
// rot_pkg
//   Shared constants and the golden rotate function for the rotator issue
//   controller (rot_issue), its result FIFO (rot_fifo) and the 32-bit right
//   rotator (rotate).
//
//   ROT_W      data width of the rotator
//   ROT_AW     width of the rotate amount
//   ROT_LAT    edges from din capture to dout valid inside the rotator
//   ROT_DEPTH  default result-FIFO depth / outstanding-request cap
//   rot_ref()  reference right-rotate, used as the golden model
// -----------------------------------------------------------------------------
package rot_pkg;

    localparam int ROT_W     = 32;
    localparam int ROT_AW    = 5;
    localparam int ROT_LAT   = 2;
    localparam int ROT_DEPTH = 4;

    // Right-rotate by concatenating the word with itself and shifting; the low
    // half then holds the rotated value for any amount 0..31.
    function automatic logic [ROT_W-1:0] rot_ref(input logic [ROT_W-1:0]  data,
                                                 input logic [ROT_AW-1:0] amt);
        logic [2*ROT_W-1:0] dbl;
        dbl = {data, data} >> amt;
        return dbl[ROT_W-1:0];
    endfunction

endpackage : rot_pkg

// File: rtl/rot_fifo.sv
// -----------------------------------------------------------------------------
// rot_fifo
//   Synchronous result FIFO, DEPTH x 32, not fall-through: a word pushed at an
//   edge becomes visible at the head only after that edge. Simultaneous push
//   and pop both happen and leave the occupancy unchanged. The head reads as
//   zero while the FIFO is empty so the downstream data bus is quiet.
//
//   Ports:
//     clock      in   rising-edge clock
//     reset      in   synchronous active-high reset (pointers and count)
//     push       in   write push_data at the tail
//     push_data  in   32
//     pop        in   drop the head
//     pop_data   out  32  head word (0 when empty)
//     count      out  log2(DEPTH)+1  occupancy
//     empty      out  count == 0
//     full       out  count == DEPTH
// -----------------------------------------------------------------------------
module rot_fifo
    import rot_pkg::*;
#(
    parameter int DEPTH = ROT_DEPTH
)(
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic [ROT_W-1:0]         push_data,
    input  logic                     pop,
    output logic [ROT_W-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);

    logic [ROT_W-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q,  count_d;
    logic          do_push;
    logic          do_pop;

    assign empty = (count_q == '0);
    assign full  = (count_q == (AW+1)'(DEPTH));

    // Guard against overflow/underflow even though the controller never
    // requests either.
    assign do_push = push && !full;
    assign do_pop  = pop  && !empty;

    // Pointers are log2(DEPTH) bits wide and wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; stale words are unreachable once the pointers
    // and count are cleared.
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = empty ? '0 : mem[rd_ptr_q];
    assign count    = count_q;

endmodule : rot_fifo

// File: rtl/rotate.sv
// -----------------------------------------------------------------------------
// rotate
//   Fixed two-stage 32-bit right rotator driven by rot_issue.
//   din is registered at edge E, amount is applied combinationally during the
//   following cycle, and the rotated word is registered into dout at edge E+1.
//   The rotator has no reset: its contents are only meaningful when the
//   controller says so.
//
//   Ports:
//     clock   in   rising-edge clock
//     din     in   32  word to rotate (captured every edge)
//     amount  in   5   right-rotate amount, must lag din by one cycle
//     dout    out  32  rotated word, registered
// -----------------------------------------------------------------------------
module rotate
    import rot_pkg::*;
(
    input  logic              clock,
    input  logic [ROT_W-1:0]  din,
    input  logic [ROT_AW-1:0] amount,
    output logic [ROT_W-1:0]  dout
);

    logic [ROT_W-1:0] din_q;
    logic [ROT_W-1:0] din_d;
    logic [ROT_W-1:0] dout_q;
    logic [ROT_W-1:0] dout_d;

    // Log-shifter: stage gi rotates by 2**gi when amount bit gi is set.
    logic [ROT_W-1:0] stage [ROT_AW+1];

    assign stage[0] = din_q;

    genvar gi;
    generate
        for (gi = 0; gi < ROT_AW; gi++) begin : g_stage
            localparam int SH = 1 << gi;
            assign stage[gi+1] = amount[gi]
                               ? {stage[gi][SH-1:0], stage[gi][ROT_W-1:SH]}
                               : stage[gi];
        end
    endgenerate

    always_comb begin
        din_d  = din;
        dout_d = stage[ROT_AW];
    end

    always_ff @(posedge clock) begin
        din_q  <= din_d;
        dout_q <= dout_d;
    end

    assign dout = dout_q;

endmodule : rotate

// File: rtl/rot_issue.sv
// -----------------------------------------------------------------------------
// rot_issue
//   Issue/collect controller for the 32-bit right rotator. Accepted requests
//   drive the rotator's din combinationally in the accept cycle and its amount
//   one cycle later (the rotator applies amount one cycle after capturing din).
//   Two cycles after accept the rotator's dout is pushed into a result FIFO,
//   so downstream back-pressure never loses a result.
//
//   Ports:
//     clock       in   rising-edge clock, shared with the rotator
//     reset       in   synchronous active-high reset
//     in_valid    in   request present
//     in_ready    out  request accepted when in_valid && in_ready
//     in_data     in   32  word to rotate
//     in_amount   in   5   right-rotate amount
//     rot_din     out  32  to rotate.din (in_data on accept, else 0)
//     rot_amount  out  5   to rotate.amount (registered, lags din by 1)
//     rot_dout    in   32  from rotate.dout
//     out_valid   out  result at FIFO head
//     out_ready   in   consumer takes the head when out_valid && out_ready
//     out_data    out  32  rotated word at FIFO head
// -----------------------------------------------------------------------------
module rot_issue
    import rot_pkg::*;
#(
    parameter int DEPTH = ROT_DEPTH   // power of two, >= 2
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ROT_W-1:0]  in_data,
    input  logic [ROT_AW-1:0] in_amount,
    output logic [ROT_W-1:0]  rot_din,
    output logic [ROT_AW-1:0] rot_amount,
    input  logic [ROT_W-1:0]  rot_dout,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ROT_W-1:0]  out_data
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [CW-1:0]     fifo_count;
    logic              fifo_empty;
    logic              fifo_full;
    logic              fifo_pop;

    logic              v1_q,  v1_d;    // request in rotator stage 1 (din captured)
    logic              v2_q,  v2_d;    // result valid on rot_dout this cycle
    logic [ROT_AW-1:0] amt_q, amt_d;   // skew register for the rotate amount

    logic [CW:0]       outstanding;
    logic              accept;

    // Every request accepted and not yet consumed holds a credit: those still
    // in the rotator (v1, v2) plus those buffered. A pop in this same cycle is
    // not credited back until the next cycle, which keeps in_ready free of
    // any combinational dependence on out_ready.
    assign outstanding = {1'b0, fifo_count} + (CW+1)'(v1_q) + (CW+1)'(v2_q);

    assign in_ready = !reset && !fifo_full && (outstanding < (CW+1)'(DEPTH));
    assign accept   = in_valid && in_ready;

    // din goes straight through so the rotator captures it at the accept edge;
    // the bus idles at zero otherwise.
    assign rot_din    = accept ? in_data : '0;
    assign rot_amount = amt_q;

    always_comb begin
        v1_d  = accept;
        v2_d  = v1_q;
        amt_d = amt_q;
        if (accept) begin
            amt_d = in_amount;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            v1_q  <= 1'b0;
            v2_q  <= 1'b0;
            amt_q <= '0;
        end else begin
            v1_q  <= v1_d;
            v2_q  <= v2_d;
            amt_q <= amt_d;
        end
    end

    assign out_valid = !fifo_empty;
    assign fifo_pop  = out_valid && out_ready;

    rot_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (v2_q),
        .push_data (rot_dout),
        .pop       (fifo_pop),
        .pop_data  (out_data),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

endmodule : rot_issue

// File: tb/tb_rot_issue.sv
// -----------------------------------------------------------------------------
// tb_rot_issue
//   Self-checking bench for rot_issue + rotate. A request-level model keeps a
//   queue of outstanding requests, each with its rotated result and the cycle
//   from which it may appear at the output; every cycle the DUT outputs are
//   compared against it. Directed cases pin the model with literal results.
// -----------------------------------------------------------------------------
module tb_rot_issue;
    import rot_pkg::*;

    localparam int DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [ROT_W-1:0]  in_data;
    logic [ROT_AW-1:0] in_amount;
    logic [ROT_W-1:0]  rot_din;
    logic [ROT_AW-1:0] rot_amount;
    logic [ROT_W-1:0]  rot_dout;
    logic              out_valid;
    logic              out_ready;
    logic [ROT_W-1:0]  out_data;

    always #5 clock = ~clock;

    rot_issue #(.DEPTH(DEPTH)) u_dut (
        .clock      (clock),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_amount  (in_amount),
        .rot_din    (rot_din),
        .rot_amount (rot_amount),
        .rot_dout   (rot_dout),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

    rotate u_rot (
        .clock  (clock),
        .din    (rot_din),
        .amount (rot_amount),
        .dout   (rot_dout)
    );

    typedef struct {
        logic [31:0] res;
        int          avail;
    } ent_t;

    ent_t        mq[$];        // outstanding requests, oldest first
    logic [4:0]  m_amt;        // amount of the most recent accept
    int          cyc;
    int          n_vec;
    int          n_bad;
    logic [31:0] pops[$];
    int          pop_cyc[$];
    int          acc_cyc[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // Per-cycle model and compare, sampled at the falling edge.
    always @(negedge clock) begin
        logic        exp_ready;
        logic        exp_valid;
        logic [31:0] exp_data;
        logic [31:0] exp_din;
        ent_t        e;
        exp_ready = !reset && (mq.size() < DEPTH);
        exp_valid = (mq.size() > 0) && (mq[0].avail <= cyc);
        exp_data  = exp_valid ? mq[0].res : 32'h0;
        exp_din   = (in_valid && exp_ready) ? in_data : 32'h0;
        if (cyc > 0) begin
            check("in_ready",   {31'b0, in_ready},   {31'b0, exp_ready});
            check("out_valid",  {31'b0, out_valid},  {31'b0, exp_valid});
            check("out_data",   out_data,            exp_data);
            check("rot_din",    rot_din,             exp_din);
            check("rot_amount", {27'b0, rot_amount}, {27'b0, m_amt});
        end
        if (reset) begin
            mq.delete();
            m_amt = 5'd0;
        end else begin
            if (exp_valid && out_ready) begin
                pops.push_back(mq[0].res);
                pop_cyc.push_back(cyc);
                void'(mq.pop_front());
            end
            if (in_valid && exp_ready) begin
                e.res   = rot_ref(in_data, in_amount);
                e.avail = cyc + 3;
                mq.push_back(e);
                m_amt = in_amount;
                acc_cyc.push_back(cyc);
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic [4:0] a);
        bit done;
        done      = 1'b0;
        in_valid  = 1'b1;
        in_data   = d;
        in_amount = a;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clock);
            if (in_ready) done = 1'b1;
            @(posedge clock);
            #1;
        end
        in_valid  = 1'b0;
        in_data   = '0;
        in_amount = '0;
        if (!done) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout data=%h got=no_accept expected=accept", d);
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && mq.size() != 0; k++) tick();
        check("drain_done", mq.size(), 0);
    endtask

    // Compare the popped result at index idx with a literal.
    task automatic chk_pop(input string name, input int idx, input logic [31:0] exp);
        if (idx < pops.size()) check(name, pops[idx], exp);
        else                   check(name, 32'hxxxx_dead, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int          p0;
        int          a0;
        logic [31:0] dv[5];
        logic [4:0]  av[5];

        n_vec = 0; n_bad = 0; cyc = 0; m_amt = 5'd0;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; in_amount = '0; out_ready = 1'b0;
        tick(); tick(); tick();

        // Reset state.
        check("rst_in_ready",   {31'b0, in_ready},   32'd0);
        check("rst_out_valid",  {31'b0, out_valid},  32'd0);
        check("rst_out_data",   out_data,            32'd0);
        check("rst_rot_din",    rot_din,             32'd0);
        check("rst_rot_amount", {27'b0, rot_amount}, 32'd0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", {31'b0, in_ready}, 32'd1);

        // Single request and its latency.
        out_ready = 1'b1;
        p0 = pops.size(); a0 = acc_cyc.size();
        send(32'h8000_0001, 5'd1);
        drain();
        chk_pop("single_data", p0, 32'hC000_0000);
        if (pops.size() > p0 && acc_cyc.size() > a0)
            check("single_latency", pop_cyc[p0] - acc_cyc[a0], 32'd3);
        else
            check("single_latency", 32'hFFFF_FFFF, 32'd3);

        // Back-to-back stream.
        p0 = pops.size(); a0 = acc_cyc.size();
        send(32'h1234_5678, 5'd4);
        send(32'hDEAD_BEEF, 5'd16);
        send(32'hA5A5_A5A5, 5'd0);
        send(32'h0000_0001, 5'd31);
        drain();
        chk_pop("stream0", p0,     32'h8123_4567);
        chk_pop("stream1", p0 + 1, 32'hBEEF_DEAD);
        chk_pop("stream2", p0 + 2, 32'hA5A5_A5A5);
        chk_pop("stream3", p0 + 3, 32'h0000_0002);
        if (acc_cyc.size() >= a0 + 4)
            check("stream_no_gap", acc_cyc[a0+3] - acc_cyc[a0], 32'd3);
        else
            check("stream_no_gap", 32'hFFFF_FFFF, 32'd3);

        // Back-pressure: exactly DEPTH accepts, then stall until a pop.
        out_ready = 1'b0;
        p0 = pops.size(); a0 = acc_cyc.size();
        for (int i = 0; i < 5; i++) begin
            dv[i] = $urandom;
            av[i] = 5'($urandom_range(0, 31));
        end
        for (int i = 0; i < 4; i++) send(dv[i], av[i]);
        in_valid = 1'b1; in_data = dv[4]; in_amount = av[4];
        for (int i = 0; i < 10; i++) tick();
        check("bp_accepts", acc_cyc.size() - a0, 32'd4);
        check("bp_in_ready", {31'b0, in_ready}, 32'd0);
        out_ready = 1'b1;
        send(dv[4], av[4]);
        drain();
        for (int i = 0; i < 5; i++) chk_pop($sformatf("bp_order%0d", i), p0 + i, rot_ref(dv[i], av[i]));

        // Skew: amount alternates every cycle on constant data.
        p0 = pops.size();
        send(32'h0000_000F, 5'd3);
        send(32'h0000_000F, 5'd7);
        send(32'h0000_000F, 5'd3);
        send(32'h0000_000F, 5'd7);
        drain();
        chk_pop("skew0", p0,     32'hE000_0001);
        chk_pop("skew1", p0 + 1, 32'h1E00_0000);
        chk_pop("skew2", p0 + 2, 32'hE000_0001);
        chk_pop("skew3", p0 + 3, 32'h1E00_0000);

        // Reset with two requests in flight and two buffered.
        out_ready = 1'b0;
        send(32'h1111_1111, 5'd1);
        send(32'h2222_2222, 5'd2);
        send(32'h3333_3333, 5'd3);
        send(32'h4444_4444, 5'd4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        out_ready = 1'b1;
        check("post_reset_out_valid", {31'b0, out_valid}, 32'd0);
        p0 = pops.size();
        for (int i = 0; i < 10; i++) tick();
        check("no_stale_results", pops.size() - p0, 32'd0);
        send(32'hCAFE_F00D, 5'd8);
        drain();
        chk_pop("fresh_after_reset", p0, 32'h0DCA_FEF0);

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 800; i++) begin
            reset     = ($urandom_range(0, 99) == 0);
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = $urandom;
            in_amount = 5'($urandom_range(0, 31));
            out_ready = ($urandom_range(0, 2) != 0);
            tick();
        end
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        drain();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule : tb_rot_issue
